// File: rtl/imagenes_pkg.sv
`default_nettype none
// imagenes_pkg: image identifiers, per-image colour table, write FSM encoding and ROM contents.
// Rev 1.0 -- initial release.
package imagenes_pkg;

  localparam logic [3:0] CALENDARIO = 4'd1;
  localparam logic [3:0] CRONO      = 4'd2;
  localparam logic [3:0] HORA       = 4'd3;
  localparam logic [3:0] AVATAR     = 4'd4;
  localparam logic [3:0] AM         = 4'd5;
  localparam logic [3:0] PM         = 4'd6;

  // Entry 0 is never displayed: image_id 0 always renders as background.
  localparam logic [0:15][11:0] COLOR_IMG = {
    12'h000, 12'hF80, 12'h0FF, 12'hFF0, 12'hF0F, 12'h8CF, 12'hFC8, 12'h0F0,
    12'hF00, 12'h00F, 12'hFFF, 12'h888, 12'h0F8, 12'h80F, 12'hF08, 12'h8F0
  };

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    PENDIENTE = 2'd1,
    ESCRIBE   = 2'd2
  } estado_t;

  // Fixed store contents: image 0 all ones, other images an X per row with the id in bits 27:24.
  function automatic logic [31:0] rom_palabra(input logic [8:0] dir);
    logic [31:0] x;
    x = (32'h8000_0000 >> dir[4:0]) | (32'h0000_0001 << dir[4:0]);
    x[27:24] = x[27:24] ^ dir[8:5];
    return (dir[8:5] == 4'd0) ? 32'hFFFF_FFFF : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memoria_imagenes.sv
`default_nettype none
// memoria_imagenes: 512-row bitmap store, synchronous read; writable RAM when
// LECTOR_IMAGENES_ESCRITURA_EN is defined, fixed ROM otherwise. Rev 1.0 -- initial release.
module memoria_imagenes
  import imagenes_pkg::*;
#(
  parameter int ANCHO_PAL = 32
) (
  input  logic                 reloj_i,
  input  logic [8:0]           rd_dir_i,
  output logic [ANCHO_PAL-1:0] rd_dato_o
`ifdef LECTOR_IMAGENES_ESCRITURA_EN
  ,
  input  logic                 we_i,
  input  logic [8:0]           wr_dir_i,
  input  logic [ANCHO_PAL-1:0] wr_dato_i
`endif
);

  logic [ANCHO_PAL-1:0] rd_dato_q;

`ifdef LECTOR_IMAGENES_ESCRITURA_EN
  logic [ANCHO_PAL-1:0] mem_q [512];

  // Read-before-write: a colliding read returns the word held before this edge.
  always_ff @(posedge reloj_i) begin
    if (we_i) mem_q[wr_dir_i] <= wr_dato_i;
    rd_dato_q <= mem_q[rd_dir_i];
  end
`else
  always_ff @(posedge reloj_i) begin
    rd_dato_q <= ANCHO_PAL'(rom_palabra(rd_dir_i));
  end
`endif

  assign rd_dato_o = rd_dato_q;

endmodule
`default_nettype wire

// File: rtl/lector_imagenes.sv
`default_nettype none
// lector_imagenes: two-stage bitmap-to-RGB444 pixel reader; LECTOR_IMAGENES_ESCRITURA_EN adds
// a blanking-only write port. Rev 1.0 -- initial release.
module lector_imagenes
  import imagenes_pkg::*;
#(
  parameter logic [11:0] COLOR_FONDO = 12'h000,
  parameter int          ANCHO_PAL   = 32
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic [8:0]  DIR_IM,
  input  logic [4:0]  px_h,
  input  logic        video_on,
  input  logic        wr_req,
  input  logic [8:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  output logic [11:0] rgb,
  output logic        pix_on
);

  logic [ANCHO_PAL-1:0] rd_dato;
  logic [3:0]           id_q;
  logic [4:0]           px_q;
  logic                 von_q;
  logic [11:0]          rgb_q, rgb_d;
  logic                 pix_on_q, pix_on_d;
  logic [4:0]           col;

`ifdef LECTOR_IMAGENES_ESCRITURA_EN
  estado_t              estado_q;
  logic [8:0]           wdir_q;
  logic [ANCHO_PAL-1:0] wdato_q;
  logic                 wr_ack_q;
  logic                 we;

  // Address and data are latched on entry to ESCRIBE so the driver may update them while pending.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      estado_q <= ESPERA;
      wdir_q   <= '0;
      wdato_q  <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      case (estado_q)
        ESPERA: begin
          if (wr_req) begin
            if (video_on) begin
              estado_q <= PENDIENTE;
            end else begin
              estado_q <= ESCRIBE;
              wdir_q   <= wr_addr;
              wdato_q  <= wr_data[ANCHO_PAL-1:0];
            end
          end
        end
        PENDIENTE: begin
          if (!video_on) begin
            estado_q <= ESCRIBE;
            wdir_q   <= wr_addr;
            wdato_q  <= wr_data[ANCHO_PAL-1:0];
          end
        end
        ESCRIBE: begin
          estado_q <= ESPERA;
          wr_ack_q <= 1'b1;
        end
        default: estado_q <= ESPERA;
      endcase
    end
  end

  assign we     = (estado_q == ESCRIBE);
  assign wr_ack = wr_ack_q;

  memoria_imagenes #(.ANCHO_PAL(ANCHO_PAL)) u_memoria (
    .reloj_i   (reloj),
    .rd_dir_i  (DIR_IM),
    .rd_dato_o (rd_dato),
    .we_i      (we),
    .wr_dir_i  (wdir_q),
    .wr_dato_i (wdato_q)
  );
`else
  logic unused_escritura;
  assign unused_escritura = ^{wr_req, wr_addr, wr_data};
  assign wr_ack           = 1'b0;

  memoria_imagenes #(.ANCHO_PAL(ANCHO_PAL)) u_memoria (
    .reloj_i   (reloj),
    .rd_dir_i  (DIR_IM),
    .rd_dato_o (rd_dato)
  );
`endif

  // Bit ANCHO_PAL-1 is the leftmost pixel of the tile.
  assign col = 5'(ANCHO_PAL - 1) - px_q;

  always_comb begin
    pix_on_d = von_q && (id_q != 4'd0) && rd_dato[col];
    rgb_d    = pix_on_d ? COLOR_IMG[id_q] : COLOR_FONDO;
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      id_q     <= '0;
      px_q     <= '0;
      von_q    <= 1'b0;
      rgb_q    <= COLOR_FONDO;
      pix_on_q <= 1'b0;
    end else begin
      id_q     <= DIR_IM[8:5];
      px_q     <= px_h;
      von_q    <= video_on;
      rgb_q    <= rgb_d;
      pix_on_q <= pix_on_d;
    end
  end

  assign rgb    = rgb_q;
  assign pix_on = pix_on_q;

endmodule
`default_nettype wire

// File: tb/tb_lector_imagenes.sv
`default_nettype none
// tb_lector_imagenes: randomized self-checking bench for lector_imagenes against a pixel-level
// model of the bitmap store; covers both LECTOR_IMAGENES_ESCRITURA_EN builds. Rev 1.0.
module tb_lector_imagenes;
  import imagenes_pkg::*;

  localparam logic [11:0] FONDO = 12'h123;

  logic        reloj = 1'b0;
  logic        resetM;
  logic [8:0]  DIR_IM;
  logic [4:0]  px_h;
  logic        video_on;
  logic        wr_req;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [11:0] rgb;
  logic        pix_on;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [512];
  logic [12:0] expq [$];
  logic        ack_q;
`ifdef LECTOR_IMAGENES_ESCRITURA_EN
  bit          mdl_ok [512];
  logic [8:0]  escritas [$];
`endif

  always #5 reloj = ~reloj;

  lector_imagenes #(.COLOR_FONDO(FONDO), .ANCHO_PAL(32)) dut (
    .reloj    (reloj),
    .resetM   (resetM),
    .DIR_IM   (DIR_IM),
    .px_h     (px_h),
    .video_on (video_on),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rgb      (rgb),
    .pix_on   (pix_on)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pix_on, rgb} for one sampled pixel, straight from the display rules.
  function automatic logic [12:0] ref_px(input logic [8:0] a, input logic [4:0] p, input logic v);
    int id;
    id = int'(a[8:5]);
    if (!v || id == 0 || !mdl[a][31 - int'(p)]) return {1'b0, FONDO};
    return {1'b1, COLOR_IMG[id]};
  endfunction

  function automatic logic [8:0] safe_addr();
`ifdef LECTOR_IMAGENES_ESCRITURA_EN
    if (escritas.size() == 0) return {4'd0, 5'($urandom)};
    return escritas[$urandom_range(0, escritas.size() - 1)];
`else
    return 9'($urandom);
`endif
  endfunction

  task automatic cyc(input logic [8:0] a, input logic [4:0] p, input logic v);
    logic [12:0] e;
    DIR_IM   = a;
    px_h     = p;
    video_on = v;
    expq.push_back(ref_px(a, p, v));
    @(posedge reloj);
    #1;
    ack_q = wr_ack;
    if (expq.size() == 2) begin
      e = expq.pop_front();
      check("pixel", 32'({pix_on, rgb}), 32'(e));
    end
  endtask

`ifdef LECTOR_IMAGENES_ESCRITURA_EN
  // Video is held high for 'busy' cycles, drops for one, and rises again during the write cycle.
  task automatic do_write(input logic [8:0] a, input logic [31:0] d, input int busy, input bit jumble);
    logic [8:0] rd;
    bit         got;
    got    = 1'b0;
    rd     = mdl_ok[a] ? a : safe_addr();
    wr_req = 1'b1;
    for (int n = 0; n <= busy + 1; n++) begin
      if (n == busy + 1) begin
        wr_addr = ~a;
        wr_data = ~d;
      end else if (jumble && n < busy) begin
        wr_addr = 9'($urandom);
        wr_data = $urandom;
      end else begin
        wr_addr = a;
        wr_data = d;
      end
      cyc(rd, 5'($urandom), (n < busy) || (n == busy + 1));
      check("wr_ack_timing", 32'(ack_q), 32'(n == busy + 1));
      if (ack_q) got = 1'b1;
    end
    wr_req = 1'b0;
    if (got) begin
      mdl[a]    = d;
      mdl_ok[a] = 1'b1;
      escritas.push_back(a);
    end
    cyc(mdl_ok[a] ? a : safe_addr(), 5'($urandom), 1'b1);
    check("wr_ack_single", 32'(ack_q), 32'd0);
  endtask
`endif

  initial begin
    resetM   = 1'b0;
    DIR_IM   = '0;
    px_h     = '0;
    video_on = 1'b0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    ack_q    = 1'b0;
    for (int a = 0; a < 512; a++) begin
      mdl[a] = '0;
`ifdef LECTOR_IMAGENES_ESCRITURA_EN
      mdl_ok[a] = 1'b0;
`else
      for (int c = 0; c < 32; c++) begin
        int  r;
        int  id;
        bit  lit;
        r  = a % 32;
        id = a / 32;
        if (id == 0) lit = 1'b1;
        else begin
          lit = (c == r) || (c == 31 - r);
          if (c >= 4 && c <= 7) lit = lit ^ (((id >> (7 - c)) & 1) != 0);
        end
        mdl[a][31 - c] = lit;
      end
`endif
    end

    repeat (3) @(posedge reloj);
    #1;
    check("reset_rgb", 32'(rgb), 32'(FONDO));
    check("reset_pix_on", 32'(pix_on), 32'd0);
    check("reset_wr_ack", 32'(wr_ack), 32'd0);
    resetM = 1'b1;

`ifdef LECTOR_IMAGENES_ESCRITURA_EN
    do_write(9'h060, 32'h8000_0001, 0, 1'b0);
`else
    wr_req  = 1'b1;
    wr_addr = 9'h060;
    wr_data = 32'h0;
    for (int n = 0; n < 8; n++) begin
      cyc(9'h060, 5'($urandom), 1'b0);
      check("rom_no_ack", 32'(ack_q), 32'd0);
    end
    wr_req = 1'b0;
`endif
    cyc(9'h060, 5'd0, 1'b1);
    cyc(9'h060, 5'd1, 1'b1);
    check("hora_px0", 32'({pix_on, rgb}), 32'({1'b1, COLOR_IMG[HORA]}));
    cyc(9'h060, 5'd31, 1'b1);
    check("hora_px1", 32'({pix_on, rgb}), 32'({1'b0, FONDO}));
    cyc(9'h060, 5'd31, 1'b1);
    check("hora_px31", 32'({pix_on, rgb}), 32'({1'b1, COLOR_IMG[HORA]}));

`ifdef LECTOR_IMAGENES_ESCRITURA_EN
    do_write(9'h01F, 32'hFFFF_FFFF, 0, 1'b0);
`endif
    cyc(9'h01F, 5'd7, 1'b1);
    cyc(9'h01F, 5'd7, 1'b1);
    check("image0_suppressed", 32'({pix_on, rgb}), 32'({1'b0, FONDO}));

`ifdef LECTOR_IMAGENES_ESCRITURA_EN
    do_write(9'h0C5, 32'h0F0F_0F0F, 0, 1'b0);
    do_write(9'h0C5, 32'hF0F0_F0F0, 10, 1'b0);
    do_write(9'h0A0, 32'h0000_FFFF, 2, 1'b1);
    do_write(9'h0A0, 32'hFFFF_0000, 0, 1'b0);

    // Reset while a write is pending: outputs drop at once, the word keeps its old value.
    wr_addr = 9'h0A0;
    wr_data = 32'h0;
    wr_req  = 1'b1;
    repeat (4) cyc(9'h0A0, 5'd0, 1'b1);
    check("pend_pix_on", 32'(pix_on), 32'd1);
    #2 resetM = 1'b0;
    #1;
    check("async_rst_rgb", 32'(rgb), 32'(FONDO));
    check("async_rst_pix_on", 32'(pix_on), 32'd0);
    check("async_rst_wr_ack", 32'(wr_ack), 32'd0);
    wr_req   = 1'b0;
    video_on = 1'b0;
    repeat (2) begin
      @(posedge reloj);
      #1;
      check("rst_no_ack", 32'(wr_ack), 32'd0);
    end
    expq.delete();
    resetM = 1'b1;
    repeat (3) cyc(9'h0A0, 5'd0, 1'b1);
    check("word_kept_after_rst", 32'({pix_on, rgb}), 32'({1'b1, COLOR_IMG[AM]}));

    for (int i = 0; i < 40; i++) begin
      do_write(9'($urandom), $urandom, $urandom_range(0, 4), 1'($urandom));
    end
`endif

    for (int i = 0; i < 300; i++) begin
      cyc(safe_addr(), 5'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lector_imagenes.md
LECTOR_IMAGENES -- requirements
Module: lector_imagenes

Interface
REQ-001 The module SHALL have parameter COLOR_FONDO, default 12'h000, the RGB444 value driven when no image pixel is lit.
REQ-002 The module SHALL have parameter ANCHO_PAL, default 32, the bitmap row word width (one bit per pixel).
REQ-003 The module SHALL have port reloj, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port resetM, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port DIR_IM, input, 9 bits: the image row address, {image_id[3:0], row[4:0]}.
REQ-006 The module SHALL have port px_h, input, 5 bits: the pixel column inside the 32-pixel tile.
REQ-007 The module SHALL have port video_on, input, 1 bit: active-video qualifier.
REQ-008 The module SHALL have port wr_req, input, 1 bit: bitmap write request, level, held until ack.
REQ-009 The module SHALL have port wr_addr, input, 9 bits: the bitmap write address.
REQ-010 The module SHALL have port wr_data, input, 32 bits: the bitmap write row.
REQ-011 The module SHALL have port wr_ack, output, 1 bit: one-cycle write-complete pulse.
REQ-012 The module SHALL have port rgb, output, 12 bits: the pixel colour.
REQ-013 The module SHALL have port pix_on, output, 1 bit: high when rgb comes from a lit image bit.

Function
REQ-014 The bitmap store SHALL be 512 x 32 bits with a synchronous read port addressed by DIR_IM.
REQ-015 Stage 1 SHALL register DIR_IM, px_h and video_on and issue the memory read.
REQ-016 Stage 2 SHALL select bit (31 - px_h) of the read word, so that bit 31 is the leftmost pixel.
REQ-017 Total latency from sampled inputs to rgb/pix_on SHALL be exactly 2 cycles, with video_on delayed identically.
REQ-018 When image_id is 0 or the delayed video_on is 0, the module SHALL drive pix_on=0 and rgb=COLOR_FONDO regardless of memory contents.
REQ-019 A lit bit SHALL drive pix_on=1 and rgb=COLOR_IMG[image_id]; an unlit bit SHALL drive pix_on=0 and rgb=COLOR_FONDO.
REQ-020 The write FSM SHALL have states ESPERA, PENDIENTE and ESCRIBE.
REQ-021 In ESPERA, wr_req with video_on=0 SHALL go to ESCRIBE, wr_req with video_on=1 SHALL go to PENDIENTE, and no request SHALL stay in ESPERA.
REQ-022 PENDIENTE SHALL go to ESCRIBE on the first cycle with video_on=0, so writes occur only during blanking.
REQ-023 ESCRIBE SHALL write wr_data to wr_addr, pulse wr_ack for exactly 1 cycle, and return to ESPERA.
REQ-024 wr_req held high after wr_ack SHALL be treated as a new request, which lets the driver deassert on ack.
REQ-025 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-026 wr_addr and wr_data SHALL be captured on entry to ESCRIBE; changes while PENDIENTE is held SHALL be tracked until then.

Reset
REQ-027 Assertion of resetM=0 SHALL immediately clear all pipeline registers, give rgb=COLOR_FONDO, pix_on=0 and wr_ack=0, and put the FSM in ESPERA.
REQ-028 Reset during PENDIENTE or ESCRIBE SHALL drop the write without issuing wr_ack; bitmap contents SHALL NOT be cleared by reset.
REQ-029 Reset release SHALL be honoured on the next rising edge of reloj, and the first valid pixel SHALL appear 2 cycles later.

Configuration
REQ-030 With macro LECTOR_IMAGENES_ESCRITURA_EN defined, the write port and FSM SHALL be present.
REQ-031 With LECTOR_IMAGENES_ESCRITURA_EN undefined, the store SHALL be a ROM with fixed initial contents, wr_ack SHALL be tied to 0, and the wr_* inputs SHALL be ignored.

Structure
REQ-032 Package imagenes_pkg SHALL hold the image_id constants (CALENDARIO=1, CRONO=2, HORA=3, AVATAR=4, AM=5, PM=6), the COLOR_IMG[16] table and the write FSM state encoding.
REQ-033 The store SHALL be the sub-module memoria_imagenes, 512x32 with one synchronous read port and one write port.

Verification
REQ-034 Write 32'h8000_0001 at 9'h060 (HORA row 0) in blanking, then read with px_h=0 -> pix_on=1 and rgb=COLOR_IMG[3] 2 cycles later; px_h=1 -> pix_on=0 and rgb=COLOR_FONDO; px_h=31 -> pix_on=1.
REQ-035 DIR_IM=9'h01F with memory all ones -> pix_on=0 and rgb=COLOR_FONDO (image 0 is suppressed).
REQ-036 Raise wr_req while video_on=1 for 10 cycles -> no wr_ack and no write; video_on falls -> wr_ack pulses exactly once, 2 cycles later.
REQ-037 Write and read 9'h0A0 in the same cycle -> old word is output, new word appears on the next read.
REQ-038 Assert resetM=0 while in PENDIENTE -> outputs are at reset values asynchronously, no wr_ack, and the target word is unchanged.
REQ-039 Build without LECTOR_IMAGENES_ESCRITURA_EN and pulse wr_req -> wr_ack stays 0 and the ROM image is read back unchanged.
